div_seq_param: RTL and testbench
================================

Name: div_seq_param

Overview:
- Parametrised sequential restoring divider; next generation of the fixed 16-bit DIVTOP divider.
- Accepts unsigned dividend/divisor on a start strobe and produces one quotient bit per clock.
- Adds operand width parameter, busy/ready handshake, start-while-busy rejection and divide-by-zero detection.
- Sits behind any controller needing integer division (datapath units, bench drivers).

Parameters:
- WIDTH, 16, operand/result width in bits (legal 2..64).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge of clk.
- dividend  input  WIDTH  numerator, latched when start is accepted.
- divisor  input  WIDTH  denominator, latched when start is accepted.
- quotient  output  WIDTH  result quotient; held until next accepted start.
- remainder  output  WIDTH  result remainder; held until next accepted start.
- ready  output  1  result valid; level, not pulse.
- busy  output  1  division in progress.
- div_by_zero  output  1  last accepted divisor was 0; valid while ready=1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, quotient=0, remainder=0, ready=0, busy=0, div_by_zero=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE: start=1 accepted.
  - Latch operands; clear ready and div_by_zero.
  - divisor==0: go to DONE next cycle.
  - Otherwise go to CALC with busy=1, partial remainder=0, counter=WIDTH.
- CALC, each cycle (restoring):
  - Shift {rem, dvd} left by 1.
  - trial = rem - divisor, computed WIDTH+1 bits wide.
  - trial non-negative: rem=trial, shift 1 into quotient LSB; else shift 0.
  - Decrement counter; at counter==1 go to DONE.
  - Exactly WIDTH CALC cycles.
- DONE (one cycle):
  - Drive quotient/remainder registers; ready=1, busy=0.
  - div_by_zero=1, quotient all-ones, remainder=dividend if divisor was 0.
  - Return to IDLE.
- Latency: start accepted at edge N -> ready=1 after edge N+WIDTH+1 (N+17 for WIDTH=16); divide-by-zero -> after edge N+2.
- ready stays 1 in IDLE until the next accepted start; it drops on the edge that accepts that start.
- start while busy or in DONE: ignored, no effect on the running operation.
- start held high in IDLE: re-accepted each time IDLE is reached (back-to-back divisions allowed).
- Operand inputs changing after acceptance: no effect.
- Reset mid-operation: immediate abort; all outputs return to reset values.
- divisor > dividend: quotient=0, remainder=dividend.
- divisor==1: quotient=dividend, remainder=0.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: extra input signed_mode (1 bit), latched with the operands.
  - When 1, operands are two's complement; magnitudes are divided.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend (truncating division).
  - Adds one fix-up cycle: latency WIDTH+2.
  - Most-negative / -1 gives quotient = most-negative, remainder=0, no flag.
- Not defined: no signed_mode port; unsigned only; latency WIDTH+1.

Decomposition:
- Package div_pkg holds:
  - state enum (IDLE, CALC, DONE, plus FIXUP under DIV_SIGNED_EN);
  - DIV_WIDTH_DEFAULT=16;
  - helper function for all-ones fill.
- Sub-module div_step (combinational): one restoring iteration; inputs rem, dvd MSB, divisor; outputs next rem and quotient bit. Instantiated once; the top holds the FSM, counter and registers.

Test Plan:
- 65/3, WIDTH=16 -> quotient=21, remainder=2, ready exactly 17 cycles after start edge, busy high for 16 cycles.
- 15/3 then 113/10 back-to-back with start held -> 5 r0, then 11 r3; ready drops on each accepting edge.
- 100/0 -> quotient=16'hFFFF, remainder=100, div_by_zero=1, ready 2 cycles after start.
- Start 65/3; pulse start with 15/3 at cycle 5 of CALC -> ignored, result still 21 r2; then rst=0 at cycle 8 of a new division -> all outputs 0 immediately, ready stays 0.
- WIDTH=8 instance, 255/1 and 7/200 -> 255 r0 and 0 r7; latency 9 cycles.
- DIV_SIGNED_EN, signed_mode=1: -7/2 -> quotient=-3 (16'hFFFD), remainder=-1 (16'hFFFF), latency 18; 7/-2 -> -3 r1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the div_seq_param sequential divider.
// The FIXUP state exists only when DIV_SIGNED_EN is defined.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 16;
    localparam int DIV_MAX_W         = 64;

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2,
        FIXUP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    // Low n bits set; n == DIV_MAX_W shifts everything out and yields all ones.
    function automatic logic [DIV_MAX_W-1:0] fill_ones(input int unsigned n);
        fill_ones = ~({DIV_MAX_W{1'b1}} << n);
    endfunction

endpackage

// File: rtl/div_seq_param_if.sv
// Request/result bundle between a division client (master) and div_seq_param (slave).
// signed_mode is present only when DIV_SIGNED_EN is defined.
interface div_seq_param_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             busy;
    logic             div_by_zero;
`ifdef DIV_SIGNED_EN
    logic             signed_mode;

    modport master (
        output start, dividend, divisor, signed_mode,
        input  quotient, remainder, ready, busy, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor, signed_mode,
        output quotient, remainder, ready, busy, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, busy, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, busy, div_by_zero
    );
`endif
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if the partial remainder allows it.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // rem < divisor always holds, so a WIDTH+1 trial keeps its sign in the MSB.
    always_comb begin
        shifted_s = {rem, dvd_msb};
        trial_s   = shifted_s - {1'b0, divisor};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_next = trial_s[WIDTH-1:0];
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_seq_param.sv
// Parametrised sequential restoring divider, one quotient bit per clock.
// Defining DIV_SIGNED_EN adds signed_mode and a sign fix-up cycle.
module div_seq_param
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    div_seq_param_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_MAX_W-1:0] ONES_FULL = fill_ones(WIDTH);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic             zero_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             ready_r;
    logic             busy_r;
    logic             dbz_r;

    logic [WIDTH-1:0] step_rem_s;
    logic             step_q_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dsr_mag_s;
    logic             neg_q_s;
    logic             neg_r_s;

`ifdef DIV_SIGNED_EN
    logic             neg_q_r;
    logic             neg_r_r;

    // Signed requests divide magnitudes; remember which results need negating.
    always_comb begin
        neg_r_s = bus.signed_mode & bus.dividend[WIDTH-1];
        neg_q_s = bus.signed_mode & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
        if (neg_r_s) begin
            dvd_mag_s = ~bus.dividend + WIDTH'(1);
        end else begin
            dvd_mag_s = bus.dividend;
        end
        if (bus.signed_mode & bus.divisor[WIDTH-1]) begin
            dsr_mag_s = ~bus.divisor + WIDTH'(1);
        end else begin
            dsr_mag_s = bus.divisor;
        end
    end
`else
    // Unsigned build: operands pass through untouched.
    always_comb begin
        neg_q_s   = 1'b0;
        neg_r_s   = 1'b0;
        dvd_mag_s = bus.dividend;
        dsr_mag_s = bus.divisor;
    end
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .dvd_msb  (dvd_r[WIDTH-1]),
        .divisor  (dsr_r),
        .rem_next (step_rem_s),
        .q_bit    (step_q_s)
    );

    // Control FSM, iteration counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            rem_r       <= '0;
            dvd_r       <= '0;
            dsr_r       <= '0;
            zero_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            dbz_r       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        ready_r <= 1'b0;
                        dbz_r   <= 1'b0;
                        rem_r   <= '0;
                        state_r <= CALC;
`ifdef DIV_SIGNED_EN
                        neg_q_r <= neg_q_s;
                        neg_r_r <= neg_r_s;
`endif
                        // A zero divisor spends one idle CALC cycle, keeping the raw dividend.
                        if (bus.divisor == '0) begin
                            zero_r <= 1'b1;
                            dvd_r  <= bus.dividend;
                            dsr_r  <= '0;
                            cnt_r  <= CNT_W'(1);
                        end else begin
                            zero_r <= 1'b0;
                            dvd_r  <= dvd_mag_s;
                            dsr_r  <= dsr_mag_s;
                            cnt_r  <= CNT_W'(WIDTH);
                            busy_r <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (zero_r) begin
                        cnt_r   <= '0;
                        state_r <= DONE;
                    end else begin
                        rem_r <= step_rem_s;
                        dvd_r <= {dvd_r[WIDTH-2:0], step_q_s};
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
`ifdef DIV_SIGNED_EN
                            state_r <= FIXUP;
`else
                            busy_r  <= 1'b0;
                            state_r <= DONE;
`endif
                        end
                    end
                end
`ifdef DIV_SIGNED_EN
                FIXUP: begin
                    if (neg_q_r) begin
                        dvd_r <= ~dvd_r + WIDTH'(1);
                    end
                    if (neg_r_r) begin
                        rem_r <= ~rem_r + WIDTH'(1);
                    end
                    busy_r  <= 1'b0;
                    state_r <= DONE;
                end
`endif
                DONE: begin
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                    if (zero_r) begin
                        dbz_r       <= 1'b1;
                        quotient_r  <= ONES_FULL[WIDTH-1:0];
                        remainder_r <= dvd_r;
                    end else begin
                        dbz_r       <= 1'b0;
                        quotient_r  <= dvd_r;
                        remainder_r <= rem_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.ready       = ready_r;
    assign bus.busy        = busy_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_seq_param.sv
// Directed bench for div_seq_param: 16-bit and 8-bit instances, hand-computed results.
// Signed vectors are exercised when DIV_SIGNED_EN is defined.
module tb_div_seq_param;
    import div_pkg::*;

`ifdef DIV_SIGNED_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT16 = 17 + EXTRA;
    localparam int LAT8  = 9 + EXTRA;

    logic clk = 1'b0;
    logic rst;
    int   checks_cnt = 0;
    int   errors_cnt = 0;
    int   cyc;

    always #5 clk = ~clk;

    div_seq_param_if #(.WIDTH(16)) if16 ();
    div_seq_param_if #(.WIDTH(8))  if8 ();

    div_seq_param #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    div_seq_param #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the 16-bit DUT idle.
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sm, input int pulse_at,
                         input logic [15:0] eq, input logic [15:0] er, input logic ed,
                         input int elat, input int ebusy);
        int n;
        int busy_n;
        if16.start    = 1'b1;
        if16.dividend = a;
        if16.divisor  = b;
`ifdef DIV_SIGNED_EN
        if16.signed_mode = sm;
`else
        if (sm) $display("note: signed vector %s run on unsigned build", tag);
`endif
        @(posedge clk); #1;
        if16.start    = 1'b0;
        if16.dividend = ~a;
        if16.divisor  = ~b;
        n      = 0;
        busy_n = 0;
        while (!if16.ready && n < 100) begin
            if (if16.busy) busy_n++;
            if (n == pulse_at) begin
                if16.start    = 1'b1;
                if16.dividend = 16'd15;
                if16.divisor  = 16'd3;
            end else begin
                if16.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"},  n, elat);
        check({tag, "_q"},    if16.quotient, eq);
        check({tag, "_r"},    if16.remainder, er);
        check({tag, "_dbz"},  if16.div_by_zero, ed);
        check({tag, "_busy"}, busy_n, ebusy);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input int elat);
        int n;
        if8.start    = 1'b1;
        if8.dividend = a;
        if8.divisor  = b;
        @(posedge clk); #1;
        if8.start    = 1'b0;
        if8.dividend = ~a;
        if8.divisor  = ~b;
        n = 0;
        while (!if8.ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, elat);
        check({tag, "_q"},   if8.quotient, eq);
        check({tag, "_r"},   if8.remainder, er);
        check({tag, "_dbz"}, if8.div_by_zero, 1'b0);
    endtask

    task automatic wait_ready16(input string tag, input int elat);
        cyc = 0;
        while (!if16.ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, elat);
    endtask

    initial begin
        rst           = 1'b0;
        if16.start    = 1'b0;
        if16.dividend = '0;
        if16.divisor  = '0;
        if8.start     = 1'b0;
        if8.dividend  = '0;
        if8.divisor   = '0;
`ifdef DIV_SIGNED_EN
        if16.signed_mode = 1'b0;
        if8.signed_mode  = 1'b0;
`endif
        #12;
        check("rst_q",     if16.quotient, 16'd0);
        check("rst_r",     if16.remainder, 16'd0);
        check("rst_ready", if16.ready, 1'b0);
        check("rst_busy",  if16.busy, 1'b0);
        check("rst_dbz",   if16.div_by_zero, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        run16("d65_3", 16'd65, 16'd3, 1'b0, -1, 16'd21, 16'd2, 1'b0, LAT16, LAT16 - 1);

        // Back-to-back with start held high; second operands appear while busy.
        if16.start    = 1'b1;
        if16.dividend = 16'd15;
        if16.divisor  = 16'd3;
        @(posedge clk); #1;
        check("b2b1_drop", if16.ready, 1'b0);
        check("b2b1_busy", if16.busy, 1'b1);
        if16.dividend = 16'd113;
        if16.divisor  = 16'd10;
        wait_ready16("b2b1", LAT16);
        check("b2b1_q", if16.quotient, 16'd5);
        check("b2b1_r", if16.remainder, 16'd0);
        @(posedge clk); #1;
        check("b2b2_drop", if16.ready, 1'b0);
        check("b2b2_busy", if16.busy, 1'b1);
        if16.start = 1'b0;
        wait_ready16("b2b2", LAT16);
        check("b2b2_q", if16.quotient, 16'd11);
        check("b2b2_r", if16.remainder, 16'd3);

        run16("dbz",    16'd100, 16'd0, 1'b0, -1, 16'hFFFF, 16'd100, 1'b1, 2, 0);
        run16("ignore", 16'd65, 16'd3, 1'b0, 5, 16'd21, 16'd2, 1'b0, LAT16, LAT16 - 1);
        run16("ffff",   16'hFFFF, 16'hFFFF, 1'b0, -1, 16'd1, 16'd0, 1'b0, LAT16, LAT16 - 1);
        run16("div1",   16'hBEEF, 16'd1, 1'b0, -1, 16'hBEEF, 16'd0, 1'b0, LAT16, LAT16 - 1);
        run16("small",  16'd7, 16'd200, 1'b0, -1, 16'd0, 16'd7, 1'b0, LAT16, LAT16 - 1);

        // Reset in the middle of a fresh division.
        if16.start    = 1'b1;
        if16.dividend = 16'd65;
        if16.divisor  = 16'd3;
        @(posedge clk); #1;
        if16.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_q",     if16.quotient, 16'd0);
        check("abort_r",     if16.remainder, 16'd0);
        check("abort_ready", if16.ready, 1'b0);
        check("abort_busy",  if16.busy, 1'b0);
        check("abort_dbz",   if16.div_by_zero, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_stay", if16.ready, 1'b0);

        run8("w8_255_1", 8'd255, 8'd1, 8'd255, 8'd0, LAT8);
        run8("w8_7_200", 8'd7, 8'd200, 8'd0, 8'd7, LAT8);

`ifdef DIV_SIGNED_EN
        run16("s_m7_2",  16'hFFF9, 16'd2, 1'b1, -1, 16'hFFFD, 16'hFFFF, 1'b0, 18, 17);
        run16("s_7_m2",  16'd7, 16'hFFFE, 1'b1, -1, 16'hFFFD, 16'd1, 1'b0, 18, 17);
        run16("s_min_1", 16'h8000, 16'hFFFF, 1'b1, -1, 16'h8000, 16'd0, 1'b0, 18, 17);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
